// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package if_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam int BYTES_PER_INST = 4;
    localparam int INST_W         = 32;
    localparam int CNT_W          = 3;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: byte memory port, IF/ID handshake and redirect.
interface if_fetch_if
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic [7:0]        mem_data_i;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_addr_i;

    modport master (
        output mem_req_o, mem_addr_o,
        output pc_o, inst_o, inst_valid_o,
        input  mem_gnt_i, mem_data_i,
        input  inst_ready_i, jump_i, jump_addr_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        input  pc_o, inst_o, inst_valid_o,
        output mem_gnt_i, mem_data_i,
        output inst_ready_i, jump_i, jump_addr_i
    );

endinterface

// File: rtl/if_byte_asm.sv
// Little-endian byte-lane assembly register for one 32-bit instruction.
module if_byte_asm
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [1:0]        lane_i,
    input  logic [7:0]        byte_i,
    output logic [INST_W-1:0] word_o
);

    logic [INST_W-1:0] word_q;

    // word_o already contains the byte written this cycle
    always_comb begin
        word_o = word_q;
        for (int l = 0; l < BYTES_PER_INST; l++) begin
            if (we_i && (lane_i == 2'(l))) begin
                word_o[8*l +: 8] = byte_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per instruction, presented with
// valid/ready to decode; decode redirects drop any partial fetch.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    if_fetch_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic              pend_q, pend_d;
    logic              drop_q, drop_d;

    logic              req;
    logic              grant;
    logic              capture;
    logic              last;
    logic              accept;
    logic [INST_W-1:0] asm_word;

    // No requests while reset is held
    assign req     = (state_q == FETCH) && !rst
                   && (issue_q < CNT_W'(BYTES_PER_INST));
    assign grant   = req && bus.mem_gnt_i;
    assign capture = pend_q && !drop_q && (state_q == FETCH);
    assign last    = capture
                   && (recv_q == CNT_W'(BYTES_PER_INST - 1));
    assign accept  = valid_q && bus.inst_ready_i;

    assign bus.mem_req_o    = req;
    assign bus.mem_addr_o   = req ? pc_q + ADDR_W'(issue_q) : '0;
    assign bus.pc_o         = pc_out_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = valid_q;

    if_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bus.jump_i || accept || last),
        .we_i   (capture && !bus.jump_i),
        .lane_i (recv_q[1:0]),
        .byte_i (bus.mem_data_i),
        .word_o (asm_word)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        issue_d  = issue_q;
        recv_d   = recv_q;
        pend_d   = grant;
        drop_d   = 1'b0;

        if (bus.jump_i) begin
            // A byte granted now returns next cycle and must be discarded
            pc_d    = bus.jump_addr_i;
            valid_d = 1'b0;
            issue_d = '0;
            recv_d  = '0;
            drop_d  = grant;
            state_d = FETCH;
        end else if (accept) begin
            pc_d    = pc_q + ADDR_W'(BYTES_PER_INST);
            valid_d = 1'b0;
            issue_d = '0;
            recv_d  = '0;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (grant) begin
                issue_d = issue_q + CNT_W'(1);
            end
            if (capture) begin
                recv_d = recv_q + CNT_W'(1);
            end
            if (last) begin
                inst_d   = asm_word;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            issue_q  <= '0;
            recv_q   <= '0;
            pend_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            issue_q  <= issue_d;
            recv_q   <= recv_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vectors, corner sequences and
// a randomized run against a transaction-level fetch model.
module tb_if_fetch;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_fetch_if #(.ADDR_W(32)) bus ();

    if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] ja;
        logic [7:0]  pat;
        int          cyc;
        logic [31:0] inst;
    } vec_t;

    vec_t vt[4];

    function automatic logic [7:0] memb(input logic [31:0] a);
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
    endfunction

    // Byte memory: data for a granted request appears the next cycle
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_gnt_i)
            bus.mem_data_i <= memb(bus.mem_addr_o);
        else
            bus.mem_data_i <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 of the first fetch cycle; returns at posedge+2
    // of the cycle where valid is seen (or after the cycle budget).
    task automatic fetch_wait(input logic [7:0] pat, input logic [31:0] base,
                              output int lat, output bit aok);
        int g;
        g   = 0;
        aok = 1'b1;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            bus.mem_gnt_i = pat[c % 8];
            #1;
            if (bus.inst_valid_o) begin
                lat = c;
                break;
            end
            if (bus.mem_req_o && bus.mem_addr_o !== base + 32'(g)) aok = 1'b0;
            if (bus.mem_req_o && bus.mem_gnt_i) g++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] ja,
                           input logic [7:0] pat, input int ecyc,
                           input logic [31:0] einst);
        int lat;
        bit aok;
        bus.jump_i      = 1'b1;
        bus.jump_addr_i = ja;
        bus.mem_gnt_i   = 1'b1;
        bus.inst_ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.jump_i = 1'b0;
        fetch_wait(pat, ja, lat, aok);
        chk({nm, "_latency"}, 32'(lat), 32'(ecyc));
        chk({nm, "_addrseq"}, 32'(aok), 32'd1);
        chk({nm, "_pc"}, bus.pc_o, ja);
        chk({nm, "_inst"}, bus.inst_o, einst);
    endtask

    initial begin
        int lat;
        bit aok;
        bit stable;
        logic [31:0] exp_pc;
        int gr;
        int accepts;

        vt[0] = '{ja: 32'h0000_0101, pat: 8'h55, cyc: 8, inst: 32'hA1A6_A7A4};
        vt[1] = '{ja: 32'h0000_02F0, pat: 8'h33, cyc: 7, inst: 32'h5657_5455};
        vt[2] = '{ja: 32'h0000_0100, pat: 8'hF0, cyc: 9, inst: 32'hA6A7_A4A5};
        vt[3] = '{ja: 32'hFFFF_FFFC, pat: 8'hFF, cyc: 5, inst: 32'h5A5B_5859};

        rst = 1'b1;
        bus.mem_gnt_i    = 1'b1;
        bus.inst_ready_i = 1'b0;
        bus.jump_i       = 1'b0;
        bus.jump_addr_i  = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);

        // First fetch after reset release
        rst = 1'b0;
        #1;
        chk("first_req", 32'(bus.mem_req_o), 32'd1);
        fetch_wait(8'hFF, 32'h0, lat, aok);
        chk("first_latency", 32'(lat), 32'd5);
        chk("first_addrseq", 32'(aok), 32'd1);
        chk("first_inst", bus.inst_o, 32'h0000_0013);
        chk("first_pc", bus.pc_o, 32'h0);

        // Backpressure: outputs frozen, no requests
        stable = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #2;
            if (bus.pc_o !== 32'h0 || bus.inst_o !== 32'h13 ||
                bus.mem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b1)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        bus.inst_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_ready_i = 1'b0;
        #1;
        chk("accept_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("accept_req", 32'(bus.mem_req_o), 32'd1);
        chk("accept_addr", bus.mem_addr_o, 32'h4);

        // Redirect after two granted bytes, third request in the jump cycle
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        run_vec("jump_midfetch", 32'h100, 8'hFF, 5, 32'hA6A7_A4A5);

        foreach (vt[i])
            run_vec($sformatf("vec%0d", i), vt[i].ja, vt[i].pat,
                    vt[i].cyc, vt[i].inst);

        // Accept at 0xFFFFFFFC wraps to 0
        bus.inst_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_ready_i = 1'b0;
        #1;
        chk("wrap_req", 32'(bus.mem_req_o), 32'd1);
        chk("wrap_addr", bus.mem_addr_o, 32'h0);
        fetch_wait(8'hFF, 32'h0, lat, aok);
        chk("wrap_inst", bus.inst_o, 32'h0000_0013);

        // Jump and accept on the same edge: jump target wins
        bus.inst_ready_i = 1'b1;
        bus.jump_i       = 1'b1;
        bus.jump_addr_i  = 32'h2F0;
        @(posedge clk);
        #1;
        bus.inst_ready_i = 1'b0;
        bus.jump_i       = 1'b0;
        #1;
        chk("jmpacc_addr", bus.mem_addr_o, 32'h2F0);
        chk("jmpacc_valid", 32'(bus.inst_valid_o), 32'd0);

        // Reset in the middle of the 0x2F0 fetch
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("midrst_req", 32'(bus.mem_req_o), 32'd0);
        chk("midrst_addr", bus.mem_addr_o, 32'h0);
        chk("midrst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("midrst_inst", bus.inst_o, 32'h0);
        chk("midrst_pc", bus.pc_o, 32'h0);
        rst = 1'b0;
        fetch_wait(8'hFF, 32'h0, lat, aok);
        chk("postrst_latency", 32'(lat), 32'd5);
        chk("postrst_inst", bus.inst_o, 32'h0000_0013);

        // Randomized traffic against a transaction-level model
        exp_pc  = 32'h0;
        gr      = 4;
        accepts = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.mem_gnt_i    = ($urandom_range(3) != 0);
            bus.inst_ready_i = ($urandom_range(2) == 0);
            bus.jump_i       = ($urandom_range(24) == 0);
            bus.jump_addr_i  = ($urandom_range(3) == 0)
                             ? 32'hFFFF_FFF8 + 32'($urandom_range(7))
                             : 32'($urandom);
            #1;
            if (bus.inst_valid_o) begin
                chk("rand_pc", bus.pc_o, exp_pc);
                chk("rand_inst", bus.inst_o, word(exp_pc));
                chk("rand_req_in_hold", 32'(bus.mem_req_o), 32'd0);
            end
            if (bus.mem_req_o) begin
                chk("rand_addr", bus.mem_addr_o, exp_pc + 32'(gr));
                chk("rand_overissue", 32'(gr < 4), 32'd1);
            end
            if (bus.jump_i) begin
                exp_pc = bus.jump_addr_i;
                gr     = 0;
            end else if (bus.inst_valid_o && bus.inst_ready_i) begin
                exp_pc = exp_pc + 32'd4;
                gr     = 0;
                accepts++;
            end else if (bus.mem_req_o && bus.mem_gnt_i) begin
                gr++;
            end
            @(posedge clk);
            #1;
        end
        chk("rand_progress", 32'(accepts > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
